// File: rtl/div_hilo_sequencer.sv
// ============================================================================
// Module      : div_hilo_sequencer
// Description : Iterative restoring DIV/DIVU sequencer that owns HI/LO and
//               raises stall for MFHI/MFLO while a divide is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_hilo_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic [WIDTH:0]   rem_shift_d;
    logic             rem_ge_d;
    logic [WIDTH:0]   rem_sub_d;
    logic [WIDTH-1:0] rem_step_d;
    logic [WIDTH-1:0] q_step_d;
    logic [WIDTH-1:0] lo_fix_d;
    logic [WIDTH-1:0] hi_fix_d;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign dvd_mag_d = (signed_op && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    assign dvs_mag_d = (signed_op && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

    // The partial remainder stays below the divisor, so only the shifted
    // value needs the extra accumulator bit.
    assign rem_shift_d = {rem_q, q_q[WIDTH-1]};
    assign rem_ge_d    = (rem_shift_d >= {1'b0, dvs_q});
    assign rem_sub_d   = rem_shift_d - {1'b0, dvs_q};
    assign rem_step_d  = rem_ge_d ? rem_sub_d[WIDTH-1:0] : rem_shift_d[WIDTH-1:0];
    assign q_step_d    = {q_q[WIDTH-2:0], rem_ge_d};

    assign lo_fix_d = zero_q   ? {WIDTH{1'b1}} :
                      sign_q_q ? (~q_q + 1'b1) : q_q;
    assign hi_fix_d = zero_q   ? dvd_raw_q :
                      sign_r_q ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            q_q       <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            cnt_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q       <= dvd_mag_d;
                        dvs_q     <= dvs_mag_d;
                        dvd_raw_q <= dividend;
                        sign_q_q  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r_q  <= signed_op & dividend[WIDTH-1];
                        zero_q    <= (divisor == '0);
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        dbz_q     <= 1'b0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    rem_q <= rem_step_d;
                    q_q   <= q_step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo_q    <= lo_fix_d;
                    hi_q    <= hi_fix_d;
                    dbz_q   <= zero_q;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign stall       = hilo_read & busy;

endmodule

`default_nettype wire

// File: tb/tb_div_hilo_sequencer.sv
// ============================================================================
// Module      : tb_div_hilo_sequencer
// Description : Scoreboard bench for div_hilo_sequencer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_hilo_sequencer;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        hilo_read;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        stall;

    div_hilo_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .hilo_read   (hilo_read),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .stall       (stall)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_x;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_b && done) begin
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_x = sb.pop_front();
                chk("lo", lo, m_x.lo);
                chk("hi", hi, m_x.hi);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_x.dbz});
                chk("done_latency", cyc, m_x.cyc);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
        prev_done <= done;
    end

    // Called at a negedge; returns the edge number at which start was sampled.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edbz, output int e);
        exp_t x;
        start     = 1'b1;
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        e = cyc;
        start = 1'b0;
        if (push) begin
            x.lo  = elo;
            x.hi  = ehi;
            x.dbz = edbz;
            x.cyc = e + 33;
            sb.push_back(x);
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_timeout", {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_vec(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi, input logic edbz);
        int e;
        issue(sgn, a, b, 1'b1, elo, ehi, edbz, e);
        wait_done();
    endtask

    initial begin
        int e;
        rst_b     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        hilo_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Basic DIVU with busy window check.
        issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, e);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done();

        run_vec(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_vec(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_vec(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        run_vec(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0);
        run_vec(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        chk("dbz_sticky_idle", {31'd0, div_by_zero}, 32'd1);

        // Read in the same IDLE cycle as start: no stall, old values seen.
        hilo_read = 1'b1;
        #1;
        chk("stall_idle_read", {31'd0, stall}, 32'd0);
        chk("idle_read_old_lo", lo, 32'hFFFFFFFF);
        issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, e);
        hilo_read = 1'b0;
        wait_done();

        // Stall window: hilo_read from edge 5 until the done cycle.
        issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0, e);
        while (cyc < e + 5) @(negedge clk);
        hilo_read = 1'b1;
        #1;
        chk("stall_run", {31'd0, stall}, 32'd1);
        while (cyc < e + 32) @(negedge clk);
        chk("stall_fix", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("stall_done_cycle", {31'd0, stall}, 32'd0);
        chk("done_with_read", {31'd0, done}, 32'd1);
        chk("read_new_lo", lo, 32'd100);
        hilo_read = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-run aborts the divide.
        issue(1'b0, 32'd55, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, e);
        while (cyc < e + 10) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (40) @(negedge clk);
        run_vec(1'b0, 32'd55, 32'd5, 32'd11, 32'd0, 1'b0);

        // Start while busy is ignored; back-to-back start right after done.
        issue(1'b0, 32'd50, 32'd6, 1'b1, 32'd8, 32'd2, 1'b0, e);
        while (cyc < e + 11) @(negedge clk);
        $display("[TB] protocol error injected: start while busy (must be ignored)");
        start     = 1'b1;
        dividend  = 32'd1;
        divisor   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e + 33) @(negedge clk);
        issue(1'b0, 32'd17, 32'd4, 1'b1, 32'd4, 32'd1, 1'b0, e);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
